// File: rtl/ex_alu_md_pkg.sv
// ex_alu_md_pkg: shared definitions for the execute stage.
//   - aluop codes (RV32I set plus the RV32M mul/div ops)
//   - alusel result-class codes, including EXE_RES_MULDIV
//   - default datapath width
//   - mul/div FSM state encoding
package ex_alu_md_pkg;

    localparam int EX_XLEN = 32;

    // aluop codes
    localparam logic [7:0] EXE_NOP_OP    = 8'h00;
    localparam logic [7:0] EXE_AND_OP    = 8'h24;
    localparam logic [7:0] EXE_OR_OP     = 8'h25;
    localparam logic [7:0] EXE_XOR_OP    = 8'h26;
    localparam logic [7:0] EXE_SLL_OP    = 8'h7c;
    localparam logic [7:0] EXE_SRL_OP    = 8'h02;
    localparam logic [7:0] EXE_SRA_OP    = 8'h03;
    localparam logic [7:0] EXE_SLT_OP    = 8'h2a;
    localparam logic [7:0] EXE_SLTU_OP   = 8'h2b;   // also used for SLTIU
    localparam logic [7:0] EXE_ADD_OP    = 8'h20;
    localparam logic [7:0] EXE_SUB_OP    = 8'h22;
    localparam logic [7:0] EXE_MUL_OP    = 8'h18;
    localparam logic [7:0] EXE_MULH_OP   = 8'h19;
    localparam logic [7:0] EXE_MULHSU_OP = 8'h1a;
    localparam logic [7:0] EXE_MULHU_OP  = 8'h1b;
    localparam logic [7:0] EXE_DIV_OP    = 8'h1c;
    localparam logic [7:0] EXE_DIVU_OP   = 8'h1d;
    localparam logic [7:0] EXE_REM_OP    = 8'h1e;
    localparam logic [7:0] EXE_REMU_OP   = 8'h1f;

    // alusel result classes
    localparam logic [2:0] EXE_RES_NOP    = 3'd0;
    localparam logic [2:0] EXE_RES_LOGIC  = 3'd1;
    localparam logic [2:0] EXE_RES_SHIFT  = 3'd2;
    localparam logic [2:0] EXE_RES_ARITH  = 3'd3;
    localparam logic [2:0] EXE_RES_MULDIV = 3'd4;

    // mul/div FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/ex_alu_md_muldiv.sv
// ex_muldiv_unit: iterative multiply/divide for the execute stage.
// Retires UNROLL result bits per cycle (shift-add multiply, restoring
// divide), both on operand magnitudes with a sign fix-up in DONE.
// Optional: EX_FAST_MUL_EN makes MUL* single-cycle (IDLE -> DONE).
// Ports:
//   clk, rst          clock, async active-high reset
//   start             a MULDIV-class op is presented (sampled in IDLE)
//   flush             abandon the op, return to IDLE
//   op, a, b          aluop and operands
//   busy              stall request (IDLE&start | CALC), masked by flush/rst
//   done              FSM is in DONE; result is valid this cycle
//   result            final sign-corrected result
module ex_muldiv_unit
    import ex_alu_md_pkg::*;
#(
    parameter int XLEN    = EX_XLEN,
    parameter int UNROLL  = 1,
    parameter int ALUOP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               flush,
    input  logic [ALUOP_W-1:0] op,
    input  logic [XLEN-1:0]    a,
    input  logic [XLEN-1:0]    b,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    result
);
    localparam int N     = XLEN / UNROLL;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    logic [1:0]         state;
    logic [CNT_W-1:0]   count;
    logic [XLEN-1:0]    hi, lo, opb;   // {hi,lo}: product, or remainder/quotient
    logic [ALUOP_W-1:0] op_q;
    logic               is_div_q, neg_q, negr_q, special;

    // operand decode
    logic            is_mul, is_div, sa, sb, a_neg, b_neg, rem_op, div0, ovf;
    logic [XLEN-1:0] ma, mb, spec_val;

    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        sa     = 1'b0;
        sb     = 1'b0;
        case (op)
            EXE_MUL_OP, EXE_MULHU_OP: is_mul = 1'b1;
            EXE_MULH_OP:              begin is_mul = 1'b1; sa = 1'b1; sb = 1'b1; end
            EXE_MULHSU_OP:            begin is_mul = 1'b1; sa = 1'b1; end
            EXE_DIV_OP, EXE_REM_OP:   begin is_div = 1'b1; sa = 1'b1; sb = 1'b1; end
            EXE_DIVU_OP, EXE_REMU_OP: is_div = 1'b1;
            default: ;
        endcase
    end

    assign a_neg  = sa & a[XLEN-1];
    assign b_neg  = sb & b[XLEN-1];
    assign ma     = a_neg ? -a : a;
    assign mb     = b_neg ? -b : b;
    assign rem_op = (op == EXE_REM_OP) | (op == EXE_REMU_OP);
    assign div0   = is_div & (b == '0);
    assign ovf    = is_div & sa & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1);

    // Special cases bypass CALC; an unknown op inside the class yields 0.
    always_comb begin
        spec_val = '0;
        if (div0)
            spec_val = rem_op ? a : '1;
        else if (ovf)
            spec_val = rem_op ? '0 : a;
    end

`ifdef EX_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, ma} * {{XLEN{1'b0}}, mb};
`endif

    // One radix-2^UNROLL step.
    logic [XLEN-1:0] nhi, nlo;
    logic [XLEN:0]   trial, diff, sum;

    always_comb begin
        nhi   = hi;
        nlo   = lo;
        trial = '0;
        diff  = '0;
        sum   = '0;
        for (int j = 0; j < UNROLL; j++) begin
            if (is_div_q) begin
                // restoring: borrow out of diff means trial < divisor
                trial = {nhi, nlo[XLEN-1]};
                diff  = trial - {1'b0, opb};
                nlo   = {nlo[XLEN-2:0], ~diff[XLEN]};
                nhi   = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
            end else begin
                // multiplier sits in lo and drains out as the product fills in
                sum = {1'b0, nhi} + (nlo[0] ? {1'b0, opb} : '0);
                nlo = {sum[0], nlo[XLEN-1:1]};
                nhi = sum[XLEN:1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            opb      <= '0;
            op_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            special  <= 1'b0;
        end else if (flush) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    op_q     <= op;
                    is_div_q <= is_div;
                    neg_q    <= a_neg ^ b_neg;
                    negr_q   <= a_neg;
                    count    <= '0;
                    hi       <= '0;
                    special  <= 1'b0;
                    if (div0 | ovf | ~(is_mul | is_div)) begin
                        lo      <= spec_val;
                        special <= 1'b1;
                        state   <= ST_DONE;
                    end
`ifdef EX_FAST_MUL_EN
                    else if (is_mul) begin
                        {hi, lo} <= fast_prod;
                        state    <= ST_DONE;
                    end
`endif
                    else begin
                        lo    <= is_div ? ma : mb;
                        opb   <= is_div ? mb : ma;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    hi    <= nhi;
                    lo    <= nlo;
                    count <= count + 1'b1;
                    if (count == CNT_W'(N - 1))
                        state <= ST_DONE;
                end
                default: state <= ST_IDLE;   // DONE and unused codes
            endcase
        end
    end

    // sign correction and result select
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    assign prod_s = neg_q  ? -{hi, lo} : {hi, lo};
    assign quo_s  = neg_q  ? -lo : lo;
    assign rem_s  = negr_q ? -hi : hi;

    always_comb begin
        result = '0;
        if (special)
            result = lo;
        else begin
            case (op_q)
                EXE_MUL_OP:                               result = prod_s[XLEN-1:0];
                EXE_MULH_OP, EXE_MULHSU_OP, EXE_MULHU_OP: result = prod_s[2*XLEN-1:XLEN];
                EXE_DIV_OP, EXE_DIVU_OP:                  result = quo_s;
                EXE_REM_OP, EXE_REMU_OP:                  result = rem_s;
                default:                                  result = '0;
            endcase
        end
    end

    assign done = (state == ST_DONE);
    assign busy = ~rst & ~flush & (((state == ST_IDLE) & start) | (state == ST_CALC));

endmodule

// File: rtl/ex_alu_md.sv
// ex_alu_md: RV32I/RV32M execute stage. Single-cycle ALU plus an
// iterative mul/div unit (ex_muldiv_unit), registered EX result and
// forwarding port. Optional: EX_FAST_MUL_EN (single-cycle MUL*).
// Ports:
//   clk, rst                         clock, async active-high reset
//   valid_i, aluop_i, alusel_i       instruction from ID/EX
//   reg1_i, reg2_i, wd_i, wreg_i     operands and destination
//   flush_i                          kill in-flight op
//   stall_o                          hold upstream while a mul/div runs
//   valid_o, wd_o, wreg_o, wdata_o   registered result to EX/MEM
//   ex_wreg_o, ex_wd_o, ex_wdata_o   forwarding to ID
module ex_alu_md
    import ex_alu_md_pkg::*;
#(
    parameter int XLEN      = EX_XLEN,
    parameter int UNROLL    = 1,
    parameter int ALUOP_W   = 8,
    parameter int REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [ALUOP_W-1:0]   aluop_i,
    input  logic [2:0]           alusel_i,
    input  logic [XLEN-1:0]      reg1_i,
    input  logic [XLEN-1:0]      reg2_i,
    input  logic [REGADDR_W-1:0] wd_i,
    input  logic                 wreg_i,
    input  logic                 flush_i,
    output logic                 stall_o,
    output logic                 valid_o,
    output logic [REGADDR_W-1:0] wd_o,
    output logic                 wreg_o,
    output logic [XLEN-1:0]      wdata_o,
    output logic                 ex_wreg_o,
    output logic [REGADDR_W-1:0] ex_wd_o,
    output logic [XLEN-1:0]      ex_wdata_o
);
    localparam int SHAMT_W = $clog2(XLEN);

    logic               md_start, md_busy, md_done, alu_go;
    logic [XLEN-1:0]    md_result, alu_res;
    logic [SHAMT_W-1:0] shamt;

    assign md_start = valid_i & (alusel_i == EXE_RES_MULDIV);
    assign shamt    = reg2_i[SHAMT_W-1:0];

    ex_muldiv_unit #(
        .XLEN    (XLEN),
        .UNROLL  (UNROLL),
        .ALUOP_W (ALUOP_W)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .flush  (flush_i),
        .op     (aluop_i),
        .a      (reg1_i),
        .b      (reg2_i),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    assign stall_o = md_busy;

    always_comb begin
        alu_res = '0;
        case (alusel_i)
            EXE_RES_NOP: alu_res = reg1_i;
            EXE_RES_LOGIC: case (aluop_i)
                EXE_AND_OP: alu_res = reg1_i & reg2_i;
                EXE_OR_OP:  alu_res = reg1_i | reg2_i;
                EXE_XOR_OP: alu_res = reg1_i ^ reg2_i;
                default:    alu_res = '0;
            endcase
            EXE_RES_SHIFT: case (aluop_i)
                EXE_SLL_OP: alu_res = reg1_i << shamt;
                EXE_SRL_OP: alu_res = reg1_i >> shamt;
                EXE_SRA_OP: alu_res = $signed(reg1_i) >>> shamt;
                default:    alu_res = '0;
            endcase
            EXE_RES_ARITH: case (aluop_i)
                EXE_ADD_OP:  alu_res = reg1_i + reg2_i;
                EXE_SUB_OP:  alu_res = reg1_i - reg2_i;
                EXE_SLT_OP:  alu_res = {{(XLEN-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
                EXE_SLTU_OP: alu_res = {{(XLEN-1){1'b0}}, reg1_i < reg2_i};
                default:     alu_res = '0;
            endcase
            default: alu_res = '0;
        endcase
    end

    // In DONE stall_o is low, so the mul/div instruction is still the one on
    // the ID/EX inputs; it must not be taken again as a new op.
    assign alu_go = valid_i & ~stall_o & ~md_done & (alusel_i != EXE_RES_MULDIV);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_o <= 1'b0;
            wd_o    <= '0;
            wreg_o  <= 1'b0;
            wdata_o <= '0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
            wreg_o  <= 1'b0;
        end else if (md_done) begin
            // wd_i/wreg_i were held by upstream for the whole op
            valid_o <= 1'b1;
            wd_o    <= wd_i;
            wreg_o  <= wreg_i;
            wdata_o <= md_result;
        end else if (alu_go) begin
            valid_o <= 1'b1;
            wd_o    <= wd_i;
            wreg_o  <= wreg_i;
            wdata_o <= alu_res;
        end else begin
            valid_o <= 1'b0;
        end
    end

    assign ex_wreg_o  = wreg_o & valid_o;
    assign ex_wd_o    = wd_o;
    assign ex_wdata_o = wdata_o;

endmodule

// File: tb/tb_ex_alu_md.sv
module tb_ex_alu_md;
    import ex_alu_md_pkg::*;

    localparam int XLEN = 32;
    localparam int UNROLL = 1;
    localparam int N = XLEN / UNROLL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [7:0]  aluop_i = '0;
    logic [2:0]  alusel_i = '0;
    logic [31:0] reg1_i = '0, reg2_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        stall_o, valid_o, wreg_o, ex_wreg_o;
    logic [4:0]  wd_o, ex_wd_o;
    logic [31:0] wdata_o, ex_wdata_o;

    always #5 clk = ~clk;

    ex_alu_md #(.XLEN(XLEN), .UNROLL(UNROLL), .ALUOP_W(8), .REGADDR_W(5)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i), .flush_i(flush_i),
        .stall_o(stall_o), .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .ex_wreg_o(ex_wreg_o), .ex_wd_o(ex_wd_o), .ex_wdata_o(ex_wdata_o)
    );

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    logic [31:0] last_model;
    int last_st;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the ISA rules.
    function automatic logic [31:0] model(input logic [7:0] op, input logic [2:0] sel,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sbv = longint'($signed(b));
        longint ua = longint'({32'd0, a});
        longint ub = longint'({32'd0, b});
        logic [63:0] p;
        int sh = int'(b[4:0]);
        case (sel)
            EXE_RES_NOP: return a;
            EXE_RES_LOGIC:
                if (op == EXE_AND_OP) return a & b;
                else if (op == EXE_OR_OP) return a | b;
                else if (op == EXE_XOR_OP) return a ^ b;
                else return 32'd0;
            EXE_RES_SHIFT:
                if (op == EXE_SLL_OP) return 32'(ua << sh);
                else if (op == EXE_SRL_OP) return 32'(ua >> sh);
                else if (op == EXE_SRA_OP) return 32'(sa >>> sh);
                else return 32'd0;
            EXE_RES_ARITH:
                if (op == EXE_ADD_OP) return 32'(ua + ub);
                else if (op == EXE_SUB_OP) return 32'(ua - ub);
                else if (op == EXE_SLT_OP) return (sa < sbv) ? 32'd1 : 32'd0;
                else if (op == EXE_SLTU_OP) return (ua < ub) ? 32'd1 : 32'd0;
                else return 32'd0;
            EXE_RES_MULDIV: begin
                case (op)
                    EXE_MUL_OP:    begin p = 64'(ua * ub);  return p[31:0];  end
                    EXE_MULH_OP:   begin p = 64'(sa * sbv); return p[63:32]; end
                    EXE_MULHSU_OP: begin p = 64'(sa * ub);  return p[63:32]; end
                    EXE_MULHU_OP:  begin p = 64'(ua * ub);  return p[63:32]; end
                    EXE_DIV_OP:
                        if (b == 0) return 32'hffffffff;
                        else if (a == 32'h80000000 && b == 32'hffffffff) return a;
                        else return 32'(sa / sbv);
                    EXE_REM_OP:
                        if (b == 0) return a;
                        else if (a == 32'h80000000 && b == 32'hffffffff) return 32'd0;
                        else return 32'(sa % sbv);
                    EXE_DIVU_OP: return (b == 0) ? 32'hffffffff : 32'(ua / ub);
                    EXE_REMU_OP: return (b == 0) ? a : 32'(ua % ub);
                    default: return 32'd0;
                endcase
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_stall(input logic [7:0] op, input logic [2:0] sel,
                                     input logic [31:0] a, input logic [31:0] b);
        bit is_mul = (op == EXE_MUL_OP) || (op == EXE_MULH_OP) || (op == EXE_MULHSU_OP) || (op == EXE_MULHU_OP);
        bit is_div = (op == EXE_DIV_OP) || (op == EXE_DIVU_OP) || (op == EXE_REM_OP) || (op == EXE_REMU_OP);
        if (sel != EXE_RES_MULDIV) return 0;
        if (!is_mul && !is_div) return 1;
        if (is_div && b == 0) return 1;
        if ((op == EXE_DIV_OP || op == EXE_REM_OP) && a == 32'h80000000 && b == 32'hffffffff) return 1;
`ifdef EX_FAST_MUL_EN
        if (is_mul) return 1;
`endif
        return N + 1;
    endfunction

    // Present one instruction, hold it while stalled, drop it after acceptance.
    task automatic issue(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd, input logic w);
        int st = 0;
        exp_t e;
        @(negedge clk);
        valid_i = 1'b1; aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = w;
        #1;
        while (stall_o) begin
            st++;
            if (st > 4 * N + 10) break;
            @(negedge clk); #1;
        end
        last_st = st;
        last_model = model(op, sel, a, b);
        chk("stall cycles", 32'(st), 32'(exp_stall(op, sel, a, b)));
        if (!stall_o) begin
            e.due = cyc + 1; e.wd = wd; e.wreg = w; e.wdata = last_model;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    // Literal expectation: pins both the DUT output and the model.
    task automatic lit(input string name, input logic [31:0] exp);
        chk({name, " dut"}, wdata_o, exp);
        chk({name, " model"}, last_model, exp);
    endtask

    // Per-cycle compare against the scoreboard.
    always @(negedge clk) begin : cmp
        exp_t e;
        if (!rst) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                chk("valid_o", 32'(valid_o), 32'd1);
                chk("wd_o", 32'(wd_o), 32'(e.wd));
                chk("wreg_o", 32'(wreg_o), 32'(e.wreg));
                chk("wdata_o", wdata_o, e.wdata);
                chk("ex_wreg_o", 32'(ex_wreg_o), 32'(e.wreg));
                chk("ex_wd_o", 32'(ex_wd_o), 32'(e.wd));
                chk("ex_wdata_o", ex_wdata_o, e.wdata);
            end else begin
                chk("valid_o bubble", 32'(valid_o), 32'd0);
                chk("ex_wreg_o bubble", 32'(ex_wreg_o), 32'd0);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hffffffff;
            3: return 32'h80000000;
            4: return 32'h7fffffff;
            5: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    logic [7:0] lops[3] = '{EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP};
    logic [7:0] sops[3] = '{EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP};
    logic [7:0] aops[4] = '{EXE_ADD_OP, EXE_SUB_OP, EXE_SLT_OP, EXE_SLTU_OP};
    logic [7:0] mops[8] = '{EXE_MUL_OP, EXE_MULH_OP, EXE_MULHSU_OP, EXE_MULHU_OP,
                            EXE_DIV_OP, EXE_DIVU_OP, EXE_REM_OP, EXE_REMU_OP};

    initial begin
        logic [7:0] op;
        logic [2:0] sel;
        int r;

        // reset state, with a mul/div presented during reset
        valid_i = 1'b1; alusel_i = EXE_RES_MULDIV; aluop_i = EXE_DIVU_OP; reg2_i = 32'd3;
        repeat (2) @(negedge clk);
        #1;
        chk("reset stall_o", 32'(stall_o), 32'd0);
        chk("reset valid_o", 32'(valid_o), 32'd0);
        chk("reset wdata_o", wdata_o, 32'd0);
        chk("reset wd_o", 32'(wd_o), 32'd0);
        chk("reset wreg_o", 32'(wreg_o), 32'd0);
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // directed cases
        issue(EXE_ADD_OP, EXE_RES_ARITH, 32'd5, 32'd7, 5'd3, 1'b1);
        lit("ADD 5+7", 32'd12);
        chk("ADD wd_o", 32'(wd_o), 32'd3);
        chk("ADD valid_o", 32'(valid_o), 32'd1);
        chk("ADD stall", 32'(last_st), 32'd0);
        issue(EXE_SRA_OP, EXE_RES_SHIFT, 32'h80000000, 32'd4, 5'd1, 1'b1);
        lit("SRA by 4", 32'hf8000000);
        issue(EXE_SRA_OP, EXE_RES_SHIFT, 32'h80000000, 32'd0, 5'd1, 1'b1);
        lit("SRA by 0", 32'h80000000);
        issue(EXE_SRL_OP, EXE_RES_SHIFT, 32'h80000000, 32'd36, 5'd1, 1'b1);
        lit("SRL by 36", 32'h08000000);
        issue(EXE_SLT_OP, EXE_RES_ARITH, 32'hffffffff, 32'd1, 5'd2, 1'b1);
        lit("SLT -1<1", 32'd1);
        issue(EXE_SLTU_OP, EXE_RES_ARITH, 32'hffffffff, 32'd1, 5'd2, 1'b1);
        lit("SLTU ffffffff<1", 32'd0);
        issue(EXE_MULHU_OP, EXE_RES_MULDIV, 32'hffffffff, 32'd2, 5'd4, 1'b1);
        lit("MULHU", 32'd1);
`ifndef EX_FAST_MUL_EN
        chk("MULHU stall", 32'(last_st), 32'd33);
`endif
        issue(EXE_MUL_OP, EXE_RES_MULDIV, 32'hffffffff, 32'd2, 5'd4, 1'b1);
        lit("MUL", 32'hfffffffe);
        issue(EXE_MUL_OP, EXE_RES_MULDIV, 32'd3, 32'hfffffffb, 5'd4, 1'b1);
        lit("MUL 3*-5", 32'hfffffff1);
        issue(EXE_MULH_OP, EXE_RES_MULDIV, 32'hfffffffd, 32'd5, 5'd4, 1'b1);
        lit("MULH -3*5", 32'hffffffff);
        issue(EXE_DIV_OP, EXE_RES_MULDIV, 32'd7, 32'd0, 5'd5, 1'b1);
        lit("DIV 7/0", 32'hffffffff);
        chk("DIV/0 stall", 32'(last_st), 32'd1);
        issue(EXE_REM_OP, EXE_RES_MULDIV, 32'd7, 32'd0, 5'd5, 1'b1);
        lit("REM 7/0", 32'd7);
        issue(EXE_DIV_OP, EXE_RES_MULDIV, 32'h80000000, 32'hffffffff, 5'd5, 1'b1);
        lit("DIV ovf", 32'h80000000);
        chk("DIV ovf stall", 32'(last_st), 32'd1);
        issue(EXE_REM_OP, EXE_RES_MULDIV, 32'h80000000, 32'hffffffff, 5'd5, 1'b1);
        lit("REM ovf", 32'd0);
        issue(EXE_DIV_OP, EXE_RES_MULDIV, 32'hfffffff9, 32'd2, 5'd6, 1'b1);
        lit("DIV -7/2", 32'hfffffffd);
        issue(EXE_REM_OP, EXE_RES_MULDIV, 32'hfffffff9, 32'd2, 5'd6, 1'b1);
        lit("REM -7/2", 32'hffffffff);
        issue(8'hee, EXE_RES_LOGIC, 32'h1234, 32'h5678, 5'd7, 1'b1);
        lit("unknown aluop", 32'd0);
        chk("unknown aluop wreg_o", 32'(wreg_o), 32'd1);
        issue(EXE_ADD_OP, 3'd7, 32'h1234, 32'h5678, 5'd7, 1'b1);
        lit("unknown alusel", 32'd0);
        issue(EXE_NOP_OP, EXE_RES_NOP, 32'hcafef00d, 32'h1, 5'd8, 1'b0);
        lit("NOP pass", 32'hcafef00d);

        // flush in CALC at count 10 (12th stalled cycle)
        @(negedge clk);
        valid_i = 1'b1; aluop_i = EXE_DIVU_OP; alusel_i = EXE_RES_MULDIV;
        reg1_i = 32'd1000; reg2_i = 32'd7; wd_i = 5'd9; wreg_i = 1'b1;
        for (int k = 0; k < 11; k++) begin
            #1; chk("DIVU stall before flush", 32'(stall_o), 32'd1);
            @(negedge clk);
        end
        flush_i = 1'b1;
        #1; chk("stall in flush cycle", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        chk("valid_o after flush", 32'(valid_o), 32'd0);
        chk("wreg_o after flush", 32'(wreg_o), 32'd0);
        issue(EXE_ADD_OP, EXE_RES_ARITH, 32'd100, 32'd23, 5'd10, 1'b1);
        lit("ADD after flush", 32'd123);

        // async reset in the middle of CALC
        @(negedge clk);
        valid_i = 1'b1; aluop_i = EXE_MULHU_OP; alusel_i = EXE_RES_MULDIV;
        reg1_i = 32'hffffffff; reg2_i = 32'd2;
        repeat (5) @(negedge clk);
        #1; rst = 1'b1; #1;
        chk("rst wdata_o", wdata_o, 32'd0);
        chk("rst wd_o", 32'(wd_o), 32'd0);
        chk("rst wreg_o", 32'(wreg_o), 32'd0);
        chk("rst valid_o", 32'(valid_o), 32'd0);
        chk("rst stall_o", 32'(stall_o), 32'd0);
        chk("rst ex_wdata_o", ex_wdata_o, 32'd0);
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 19));
            if (r == 0) begin sel = EXE_RES_NOP; op = 8'($urandom); end
            else if (r < 4) begin sel = EXE_RES_LOGIC; op = lops[$urandom_range(0, 2)]; end
            else if (r < 7) begin sel = EXE_RES_SHIFT; op = sops[$urandom_range(0, 2)]; end
            else if (r < 11) begin sel = EXE_RES_ARITH; op = aops[$urandom_range(0, 3)]; end
            else if (r < 18) begin sel = EXE_RES_MULDIV; op = mops[$urandom_range(0, 7)]; end
            else if (r == 18) begin sel = EXE_RES_MULDIV; op = 8'hee; end
            else begin sel = 3'd6; op = EXE_ADD_OP; end
            issue(op, sel, pick_val(), pick_val(), 5'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_alu_md.md
Name: ex_alu_md

Overview:
- Parametrised execute stage for the RV32I/RV32M core: single-cycle integer ALU (logic/arith/shift/compare) plus an iterative multiply/divide unit.
- Sits between ID/EX and EX/MEM.
- Owns a registered EX result and forwarding port.
- Raises a stall request to the pipeline control while a multi-cycle op is in flight.

Parameters:
- XLEN, 32, datapath width; must be a power of 2, >= 8.
- UNROLL, 1, mul/div result bits retired per cycle; must divide XLEN.
- ALUOP_W, 8, width of aluop_i.
- REGADDR_W, 5, register-address width.
- Derived, localparam: SHAMT_W = log2(XLEN); N = XLEN/UNROLL.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- valid_i  in  1  an instruction is present on the ID/EX inputs
- aluop_i  in  ALUOP_W  operation code
- alusel_i  in  3  result class (LOGIC, ARITH, SHIFT, MULDIV, NOP)
- reg1_i  in  XLEN  operand 1
- reg2_i  in  XLEN  operand 2 / immediate
- wd_i  in  REGADDR_W  destination register
- wreg_i  in  1  write-enable for wd_i
- flush_i  in  1  kill the in-flight op (branch/exception)
- stall_o  out  1  stall request; upstream holds all inputs stable while high
- valid_o  out  1  result register holds a valid instruction
- wd_o  out  REGADDR_W  registered destination
- wreg_o  out  1  registered write-enable
- wdata_o  out  XLEN  registered result
- ex_wreg_o  out  1  forward to ID; equals wreg_o & valid_o
- ex_wd_o  out  REGADDR_W  forward to ID; equals wd_o
- ex_wdata_o  out  XLEN  forward to ID; equals wdata_o

Behaviour:
- Reset (async, rst=1): all registered outputs are 0; FSM goes to IDLE; counter is 0; stall_o is 0.
- Single-cycle ops (LOGIC/ARITH/SHIFT/NOP):
  - When valid_i & !stall_o, the result is registered at the next rising edge.
  - Latency 1; valid_o=1 for one cycle unless a new op follows.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLT is signed; SLTU/SLTIU are unsigned; the result is zero-extended 0/1.
  - Shifts use reg2_i[SHAMT_W-1:0] only.
  - SRA is a true arithmetic shift: sign-filled, correct for shamt=0.
  - NOP passes reg1_i.
- MULDIV FSM, states IDLE, CALC, DONE:
  - IDLE: valid_i & MULDIV class -> capture operands, record sign-fixups, count=0.
    - Divisor zero or signed overflow -> DONE.
    - Otherwise -> CALC.
  - CALC: one radix-2^UNROLL step per cycle (shift-add multiply, restoring divide on magnitudes). count == N-1 -> DONE.
  - DONE: apply sign correction and select the result; load the output registers at the edge leaving DONE; -> IDLE.
- stall_o (combinational) = (IDLE & valid_i & MULDIV) | CALC. It is 0 in DONE, so upstream advances on the same edge the result is registered.
- MULDIV latency: N+2 cycles from acceptance to valid_o; stall_o is high for N+1 cycles. Special cases take 2 cycles with stall_o high for 1.
- While a MULDIV op is in flight, valid_o=0 (bubble into MEM).
- Op semantics:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits (s×s, s×u, u×u).
  - DIV/DIVU/REM/REMU truncate toward zero; the remainder takes the dividend's sign.
- Divide by zero: quotient = all ones; remainder = dividend.
- Signed overflow (DIV of -2^(XLEN-1) by -1): quotient = dividend; remainder = 0.
- flush_i (highest priority, synchronous):
  - Next edge: FSM -> IDLE, valid_o=0, wreg_o=0.
  - stall_o drops combinationally in the flush cycle.
- Unknown aluop within a valid class: result 0, wreg passed through.
- Unknown alusel: result 0.

Optional Feature:
- EX_FAST_MUL_EN defined: MUL* ops use a single-cycle combinational XLEN×XLEN multiplier, going IDLE -> DONE (latency 2, stall 1 cycle). DIV/REM stay iterative.
- Undefined: all MUL* ops are iterative as above.

Decomposition:
- Shared package: aluop codes (existing set plus EXE_MUL_OP, EXE_MULH_OP, EXE_MULHSU_OP, EXE_MULHU_OP, EXE_DIV_OP, EXE_DIVU_OP, EXE_REM_OP, EXE_REMU_OP), alusel codes including EXE_RES_MULDIV, default XLEN, the FSM state encoding.
- One sub-module: ex_muldiv_unit, containing the FSM, counter, iterative datapath and special cases. It has a start/busy/done interface to the top.

Test Plan:
- ADD 5+7, wd=3, wreg=1 -> next edge wdata_o=12, wd_o=3, valid_o=1, stall_o never asserted.
- SRA 0x80000000 by 4 -> 0xF8000000; SRA by 0 -> 0x80000000; SLT 0xFFFFFFFF<1 -> 1; SLTU 0xFFFFFFFF<1 -> 0.
- MULHU 0xFFFFFFFF×2 (XLEN=32, UNROLL=1):
  - stall_o high exactly 33 cycles; wdata_o=1 after cycle 34.
  - MUL of the same operands gives 0xFFFFFFFE.
  - Repeat with UNROLL=4: stall 9 cycles.
- DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with REM 0. Each takes 2-cycle latency; DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
- DIVU started, flush_i pulsed in CALC count 10 -> stall_o low that cycle, valid_o=0, then ADD accepted next cycle completes normally. Repeat with rst asserted mid-CALC -> all outputs 0 immediately.
- Build with EX_FAST_MUL_EN: MUL 3×-5 -> 0xFFFFFFF1 with stall_o high 1 cycle; DIVU still stalls N+1 cycles.
